dft_frame_seq: RTL and testbench
================================

# dft_frame_seq

Upstream sample sequencer for the DFT accumulator stage. It captures one frame of N real samples from a valid/ready stream into local RAM. It then replays the frame once per frequency bin k = 0..NBINS-1, tagging each sample with its twiddle index (k·n) mod N, so the downstream multiply-accumulate can address its sin/cos tables directly. Bin boundaries are marked with first/last flags for accumulator clear and dump.

## Interface
- N, 64, frame length; must be a power of two, ≥ 4
- NBINS, 64, bins replayed per frame; 1 ≤ NBINS ≤ N
- SW, 16, sample width (signed, two's complement)
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- s_data_i  in  SW  input sample
- s_valid_i  in  1  input sample valid
- s_ready_o  out  1  sequencer can accept a sample
- m_data_o  out  SW  replayed sample x[n]
- m_tw_idx_o  out  log2(N)  twiddle table index (k·n) mod N
- m_bin_o  out  log2(N)  current bin k
- m_first_o  out  1  n == 0 (accumulator clear)
- m_last_o  out  1  n == N-1 (accumulator result valid after this beat)
- m_valid_o  out  1  output beat valid
- m_ready_i  in  1  downstream accepts beat
- frame_done_o  out  1  one-cycle pulse after the final beat of bin NBINS-1 is accepted

## Operation
- Input handshake: a sample transfers on a rising edge with s_valid_i & s_ready_o. It is written to RAM at wr_ptr, and wr_ptr increments.
- Output handshake: a beat transfers on m_valid_o & m_ready_i. While m_valid_o=1 and m_ready_i=0, all m_* outputs hold stable.
- FSM states are FILL and REPLAY.
  - FILL: s_ready_o=1, m_valid_o=0. Accepting sample N-1 moves to REPLAY with n=0, k=0, tw=0.
  - REPLAY: s_ready_o=0. Each accepted beat advances n and adds k to tw, with tw wrapping mod N by natural overflow.
  - At n=N-1 the bin ends: n←0, tw←0, k←k+1.
  - Accepting the beat with k=NBINS-1 and n=N-1 pulses frame_done_o and returns to FILL.
- m_tw_idx_o equals (m_bin_o·n) mod N exactly. It is computed incrementally; no multiplier.
- RAM read is registered (1 cycle). The output register loads when !m_valid_o or m_ready_i, which gives one beat per cycle under continuous ready.
- Reset: wr_ptr, n, k, tw = 0; state = FILL; s_ready_o=1; m_valid_o, m_first_o, m_last_o, frame_done_o = 0; m_data_o, m_tw_idx_o, m_bin_o = 0. A partial frame, or a replay in progress, is discarded. RAM contents are don't-care.
- s_valid_i gaps during FILL only stall wr_ptr; there is no timeout.

## Timing
- Sample N-1 accepted at edge T → m_valid_o=1 after edge T+1, with first beat n=0, k=0, m_first_o=1.
- Beat throughput is 1/cycle while m_ready_i=1.
- Replay lasts N·NBINS beats. Without backpressure, the last beat occupies edge T+N·NBINS.
- frame_done_o is high for the one cycle following acceptance of the last beat.
- Non-pingpong build: s_ready_o returns to 1 in the same cycle frame_done_o is asserted.

## Configuration
- DFT_FRAME_PINGPONG_EN defined: two RAM banks.
  - Filling the alternate bank continues during REPLAY; s_ready_o=1 unless the fill bank is already full and the replay bank has not finished.
  - A full fill bank starts replay immediately after frame_done_o, with no bubble: the next frame's first beat follows the last beat on the next edge.
  - Reset clears both banks' full flags.
- Undefined: single bank as described in Operation; s_ready_o=0 throughout REPLAY.

## Structure
- Package dft_pkg holds:
  - typedef idx_t = logic [$clog2(N)-1:0]
  - localparam for default N/SW
  - the FSM state enum (FILL, REPLAY)
  - a shared sample_t typedef also used by the accumulator stage
- Sub-module dft_sample_ram: simple dual-port, one write port and one registered read port, depth N (2N with pingpong, bank select as address MSB).

## Test plan
- N=8, NBINS=8, ramp input 0..7 with continuous ready → 64 beats. Bin k=3 tw sequence is 0,3,6,1,4,7,2,5, and data is 0..7 for every bin. frame_done_o pulses once.
- m_ready_i toggled randomly (50%) → beat sequence identical to the continuous case, with outputs held stable during stalls.
- s_valid_i with gaps during FILL → replay starts exactly 1 cycle after the 8th accepted sample. s_ready_o=0 during replay (non-pingpong).
- rst asserted mid-REPLAY at k=2,n=5 → outputs reach their reset values immediately. A new 8-sample frame then replays from k=0 correctly.
- NBINS=3 → exactly 24 beats; m_bin_o never exceeds 2.
- DFT_FRAME_PINGPONG_EN, two back-to-back frames streamed continuously → second frame's k=0,n=0 beat immediately follows first frame's last beat, with no input samples lost.

Source files
------------

// File: rtl/dft_pkg.sv
// Shared types for the DFT sample sequencer and the downstream accumulator stage.
package dft_pkg;

  localparam int DFT_N  = 64;
  localparam int DFT_SW = 16;

  typedef logic [$clog2(DFT_N)-1:0] idx_t;
  typedef logic signed [DFT_SW-1:0] sample_t;

  typedef enum logic {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } state_e;

endpackage

// File: rtl/dft_frame_seq_if.sv
// Sample-in / beat-out stream bundle of the DFT frame sequencer.
interface dft_frame_seq_if
  import dft_pkg::*;
#(
  parameter int N  = DFT_N,
  parameter int SW = DFT_SW
);
  localparam int AW = $clog2(N);

  logic signed [SW-1:0] s_data_i;
  logic                 s_valid_i;
  logic                 s_ready_o;
  logic signed [SW-1:0] m_data_o;
  logic [AW-1:0]        m_tw_idx_o;
  logic [AW-1:0]        m_bin_o;
  logic                 m_first_o;
  logic                 m_last_o;
  logic                 m_valid_o;
  logic                 m_ready_i;
  logic                 frame_done_o;

  // slave is the sequencer's view, master the surrounding pipeline's
  modport slave (
    input  s_data_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_tw_idx_o, m_bin_o, m_first_o, m_last_o,
           m_valid_o, frame_done_o
  );

  modport master (
    output s_data_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_tw_idx_o, m_bin_o, m_first_o, m_last_o,
           m_valid_o, frame_done_o
  );
endinterface

// File: rtl/dft_sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port with enable.
module dft_sample_ram
  import dft_pkg::*;
#(
  parameter int DEPTH = DFT_N,
  parameter int SW    = DFT_SW,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [SW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [SW-1:0] rd_data
);
  logic [SW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The read register doubles as the output data register, so it holds under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/dft_frame_seq.sv
// Captures an N-sample frame and replays it once per bin with incremental twiddle index.
// Optional DFT_FRAME_PINGPONG_EN: two banks, fill of the next frame overlaps replay.
module dft_frame_seq
  import dft_pkg::*;
#(
  parameter int N     = DFT_N,
  parameter int NBINS = DFT_N,
  parameter int SW    = DFT_SW
) (
  input  logic           clk,
  input  logic           rst,
  dft_frame_seq_if.slave bus
);
  localparam int AW = $clog2(N);
`ifdef DFT_FRAME_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif
  localparam int RAW   = AW + int'(PP);
  localparam int DEPTH = N * (PP ? 2 : 1);
  localparam logic [AW-1:0] N_LAST = AW'(N - 1);
  localparam logic [AW-1:0] K_LAST = AW'(NBINS - 1);

  state_e        state_reg;
  logic [AW-1:0] wr_ptr_reg, n_reg, k_reg, tw_reg;
  logic          wr_bank_reg, iss_bank_reg, m_bank_reg;
  logic [1:0]    full_reg, full_next, pend_reg, pend_next;
  logic          m_valid_reg, m_first_reg, m_last_reg, done_reg;
  logic [AW-1:0] m_tw_reg, m_bin_reg;
  logic [RAW-1:0] wr_addr, rd_addr;
  logic          s_fire, m_adv, issue, fill_end, issue_end, frame_end;

  assign bus.s_ready_o = !full_reg[wr_bank_reg];
  assign s_fire        = bus.s_valid_i && bus.s_ready_o;
  assign fill_end      = s_fire && (wr_ptr_reg == N_LAST);
  assign m_adv         = !m_valid_reg || bus.m_ready_i;
  assign issue         = m_adv && (state_reg == REPLAY) && pend_reg[iss_bank_reg];
  assign issue_end     = issue && (n_reg == N_LAST) && (k_reg == K_LAST);
  assign frame_end     = m_valid_reg && bus.m_ready_i && m_last_reg && (m_bin_reg == K_LAST);

`ifdef DFT_FRAME_PINGPONG_EN
  assign wr_addr = {wr_bank_reg, wr_ptr_reg};
  assign rd_addr = {iss_bank_reg, n_reg};
`else
  assign wr_addr = wr_ptr_reg;
  assign rd_addr = n_reg;
`endif

  // full: bank holds a frame not yet fully accepted downstream (gates the writer).
  // pend: bank still has beats left to issue (gates the reader).
  always_comb begin
    full_next = full_reg;
    pend_next = pend_reg;
    if (frame_end) full_next[m_bank_reg]   = 1'b0;
    if (issue_end) pend_next[iss_bank_reg] = 1'b0;
    if (fill_end) begin
      full_next[wr_bank_reg] = 1'b1;
      pend_next[wr_bank_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= FILL;
      wr_ptr_reg   <= '0;
      n_reg        <= '0;
      k_reg        <= '0;
      tw_reg       <= '0;
      wr_bank_reg  <= 1'b0;
      iss_bank_reg <= 1'b0;
      m_bank_reg   <= 1'b0;
      full_reg     <= '0;
      pend_reg     <= '0;
      m_valid_reg  <= 1'b0;
      m_first_reg  <= 1'b0;
      m_last_reg   <= 1'b0;
      m_tw_reg     <= '0;
      m_bin_reg    <= '0;
      done_reg     <= 1'b0;
    end else begin
      full_reg  <= full_next;
      pend_reg  <= pend_next;
      state_reg <= (|full_next) ? REPLAY : FILL;
      done_reg  <= frame_end;
      if (s_fire) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (fill_end) wr_bank_reg <= wr_bank_reg ^ PP;
      end
      if (issue) begin
        m_valid_reg <= 1'b1;
        m_first_reg <= (n_reg == '0);
        m_last_reg  <= (n_reg == N_LAST);
        m_tw_reg    <= tw_reg;
        m_bin_reg   <= k_reg;
        m_bank_reg  <= iss_bank_reg;
        n_reg       <= n_reg + 1'b1;
        // tw tracks k*n mod N by repeated addition; wraps naturally at 2^AW
        if (n_reg == N_LAST) begin
          tw_reg <= '0;
          if (k_reg == K_LAST) begin
            k_reg        <= '0;
            iss_bank_reg <= iss_bank_reg ^ PP;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end else begin
          tw_reg <= tw_reg + k_reg;
        end
      end else if (m_adv) begin
        m_valid_reg <= 1'b0;
        m_first_reg <= 1'b0;
        m_last_reg  <= 1'b0;
      end
    end
  end

  dft_sample_ram #(.DEPTH(DEPTH), .SW(SW)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s_fire),
    .wr_addr (wr_addr),
    .wr_data (bus.s_data_i),
    .rd_en   (issue),
    .rd_addr (rd_addr),
    .rd_data (bus.m_data_o)
  );

  assign bus.m_tw_idx_o   = m_tw_reg;
  assign bus.m_bin_o      = m_bin_reg;
  assign bus.m_first_o    = m_first_reg;
  assign bus.m_last_o     = m_last_reg;
  assign bus.m_valid_o    = m_valid_reg;
  assign bus.frame_done_o = done_reg;
endmodule

// File: tb/tb_dft_frame_seq.sv
// Self-checking bench for dft_frame_seq: N=8 with NBINS=8 and NBINS=3 instances.
module tb_dft_frame_seq;
  localparam int N   = 8;
  localparam int SW  = 16;
  localparam int AW  = 3;
  localparam int NB3 = 3;
`ifdef DFT_FRAME_PINGPONG_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dft_frame_seq_if #(.N(N), .SW(SW)) b8 ();
  dft_frame_seq_if #(.N(N), .SW(SW)) b3 ();

  dft_frame_seq #(.N(N), .NBINS(N),   .SW(SW)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  dft_frame_seq #(.N(N), .NBINS(NB3), .SW(SW)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  typedef struct {
    int k;
    int n;
    int data;
    int tw;
  } vec_t;

  typedef struct packed {
    logic          valid;
    logic          first;
    logic          last;
    logic          done;
    logic          s_ready;
    logic [SW-1:0] data;
    logic [AW-1:0] tw;
    logic [AW-1:0] bin;
  } obs_t;

  int   total = 0;
  int   bad   = 0;
  int   frm [2*N];
  int   cap_data [N*N];
  int   cap_tw [N*N];
  vec_t vec [12];
  obs_t o0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic observe(input int which, output obs_t o);
    if (which == 0)
      o = '{b8.m_valid_o, b8.m_first_o, b8.m_last_o, b8.frame_done_o, b8.s_ready_o,
            b8.m_data_o, b8.m_tw_idx_o, b8.m_bin_o};
    else
      o = '{b3.m_valid_o, b3.m_first_o, b3.m_last_o, b3.frame_done_o, b3.s_ready_o,
            b3.m_data_o, b3.m_tw_idx_o, b3.m_bin_o};
  endtask

  task automatic drive(input int which, input logic sv, input logic [SW-1:0] sd, input logic mr);
    b8.s_valid_i = (which == 0) && sv;
    b8.s_data_i  = sd;
    b8.m_ready_i = (which == 0) ? mr : 1'b1;
    b3.s_valid_i = (which == 1) && sv;
    b3.s_data_i  = sd;
    b3.m_ready_i = (which == 1) ? mr : 1'b1;
  endtask

  // Streams nfr frames from frm[] and checks every accepted beat against
  // x[n], (k*n) mod N, k, n==0, n==N-1 in bin-major order.
  task automatic run(input int which, input int nb, input int nfr, input int rdy_pct,
                     input int gap_pct, input int stop_beat, input bit capture);
    int   acc = 0, beats = 0, dones = 0;
    int   first_cyc = -1, fill_cyc = -1, end_cyc = -100;
    int   tot_beats, budget, f, r, k, n;
    bit   stalled = 1'b0;
    obs_t o, prev;
    logic sv, mr;
    tot_beats = nfr * N * nb;
    budget    = 200 + tot_beats * 6;
    prev      = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      observe(which, o);
      if (stalled)
        chk("stall_hold", {o.valid, o.first, o.last, o.data, o.tw, o.bin},
            {prev.valid, prev.first, prev.last, prev.data, prev.tw, prev.bin});
      if (o.done) begin
        dones++;
        chk("done_timing", c, end_cyc + 1);
      end
      chk("s_ready", o.s_ready, ((acc / N) - dones) < NBANK);
      if (o.valid && first_cyc < 0) begin
        first_cyc = c;
        chk("first_latency", c, fill_cyc + 2);
      end
      if (rdy_pct == 100 && beats > 0 && beats < tot_beats)
        chk("no_bubble", o.valid, 1'b1);
      if (stop_beat >= 0 && o.valid && beats == stop_beat) begin
        chk("pre_rst_bin", o.bin, stop_beat / N);
        rst = 1'b1;
        #1;
        observe(which, o);
        chk("rst_outputs", {o.valid, o.first, o.last, o.done, o.s_ready, o.data, o.tw, o.bin},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 3'd0, 3'd0});
        return;
      end
      mr = ($urandom_range(99) < rdy_pct);
      sv = (acc < nfr * N) && ($urandom_range(99) >= gap_pct);
      drive(which, sv, 16'(frm[(acc < 2*N) ? acc : 0]), mr);
      if (sv && o.s_ready) begin
        acc++;
        if (acc == N) fill_cyc = c;
      end
      if (o.valid && mr) begin
        f = beats / (N * nb);
        r = beats % (N * nb);
        k = r / N;
        n = r % N;
        chk("beat", {o.data, o.tw, o.bin, o.first, o.last},
            {16'(frm[f*N + n]), 3'((k * n) % N), 3'(k), n == 0, n == N - 1});
        if (capture && beats < N*N) begin
          cap_data[beats] = int'(o.data);
          cap_tw[beats]   = int'(o.tw);
        end
        beats++;
        if (beats % (N * nb) == 0) end_cyc = c;
      end
      stalled = o.valid && !mr;
      prev    = o;
      if (dones == nfr && c >= end_cyc + 4) break;
    end
    chk("beat_count", beats, tot_beats);
    chk("done_count", dones, nfr);
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 2*N; i++) frm[i] = int'($urandom_range(65535));
  endtask

  initial begin
    int tws [8] = '{0, 3, 6, 1, 4, 7, 2, 5};
    for (int i = 0; i < 8; i++) vec[i] = '{3, i, i, tws[i]};
    vec[8]  = '{0, 7, 7, 0};
    vec[9]  = '{7, 7, 7, 1};
    vec[10] = '{5, 3, 3, 7};
    vec[11] = '{1, 1, 1, 1};

    drive(0, 1'b0, 16'd0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    observe(0, o0);
    chk("reset_state", {o0.valid, o0.first, o0.last, o0.done, o0.s_ready, o0.data, o0.tw, o0.bin},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 3'd0, 3'd0});
    rst = 1'b0;

    // ramp frame, continuous ready, then spot-check the captured replay
    for (int i = 0; i < 2*N; i++) frm[i] = i;
    run(0, N, 1, 100, 0, -1, 1'b1);
    for (int i = 0; i < 12; i++)
      chk($sformatf("vec_k%0d_n%0d", vec[i].k, vec[i].n),
          {cap_data[vec[i].k*N + vec[i].n], cap_tw[vec[i].k*N + vec[i].n]},
          {vec[i].data, vec[i].tw});

    rand_frame();
    run(0, N, 1, 50, 0, -1, 1'b0);

    rand_frame();
    run(0, N, 1, 100, 60, -1, 1'b0);

    // reset while presenting bin 2, sample 5, then a fresh frame
    rand_frame();
    run(0, N, 1, 100, 0, 2*N + 5, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rand_frame();
    run(0, N, 1, 70, 20, -1, 1'b0);

    rand_frame();
    run(1, NB3, 1, 60, 10, -1, 1'b0);

`ifdef DFT_FRAME_PINGPONG_EN
    rand_frame();
    run(0, N, 2, 100, 0, -1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
